text_pixel_serializer: RTL

Downstream consumer of `text_pixel_generator`. It turns the generator's 8-pixel character rows into a one-pixel-per-strobe stream for the video output stage. It drives the generator's `toggle_restart` and `toggle_next` handshakes and prefetches one byte ahead into a hold register. It also maps each pixel bit to a foreground or background RGB colour.

---
 rtl/text_pixel_serializer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/text_pixel_serializer.sv
// Serialises 8-pixel character rows into one pixel per strobe,
// driving the generator handshakes and prefetching one byte ahead.
module text_pixel_serializer #(
  parameter int unsigned FETCH_LATENCY = 4,
  parameter logic [23:0] FG_COLOR      = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR      = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pixel_en,
  input  logic [7:0]  cur_pixels,
  output logic        toggle_restart,
  output logic        toggle_next,
  output logic        pixel_valid,
  output logic        pixel_on,
  output logic [23:0] pixel_rgb,
  output logic        ready,
  output logic        underrun
);

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1,
    RUN
  } state_t;

  localparam logic [3:0] LAT = 4'(FETCH_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        ready_q, ready_d;
  logic        underrun_q, underrun_d;
  logic        tog_restart_q, tog_restart_d;
  logic        tog_next_q, tog_next_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_on_q, pix_on_d;
  logic [23:0] pix_rgb_q, pix_rgb_d;

  logic        capture;
  logic        bypass;

  // Next-state, fetch sequencing and pixel output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    bitcnt_d      = bitcnt_q;
    ready_d       = ready_q;
    underrun_d    = underrun_q;
    tog_restart_d = tog_restart_q;
    tog_next_d    = tog_next_q;
    pix_valid_d   = pixel_en;
    pix_on_d      = 1'b0;
    capture       = (cnt_q == 4'd1);
    bypass        = 1'b0;

    if (frame_start) begin
      tog_restart_d = ~tog_restart_q;
      shift_d       = 8'h00;
      hold_d        = 8'h00;
      hold_full_d   = 1'b0;
      bitcnt_d      = 3'd0;
      ready_d       = 1'b0;
      underrun_d    = 1'b0;
      cnt_d         = LAT;
      state_d       = FILL0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        FILL0: begin
          if (pixel_en) underrun_d = 1'b1;
          if (capture) begin
            shift_d    = cur_pixels;
            bitcnt_d   = 3'd0;
            tog_next_d = ~tog_next_q;
            cnt_d      = LAT;
            state_d    = FILL1;
          end
        end
        FILL1: begin
          if (pixel_en) underrun_d = 1'b1;
          if (capture) begin
            hold_d      = cur_pixels;
            hold_full_d = 1'b1;
            ready_d     = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (pixel_en) begin
            pix_on_d = shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                tog_next_d  = ~tog_next_q;
                cnt_d       = LAT;
              end else if (capture) begin
                // Byte lands exactly when needed: skip the hold stage.
                bypass     = 1'b1;
                shift_d    = cur_pixels;
                tog_next_d = ~tog_next_q;
                cnt_d      = LAT;
              end else begin
                // Fetch still pending; blank this character.
                shift_d    = 8'h00;
                underrun_d = 1'b1;
              end
            end
          end
          if (capture && !bypass) begin
            hold_d      = cur_pixels;
            hold_full_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (!pix_valid_d)  pix_rgb_d = 24'h000000;
    else if (pix_on_d) pix_rgb_d = FG_COLOR;
    else               pix_rgb_d = BG_COLOR;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      shift_q       <= 8'h00;
      hold_q        <= 8'h00;
      hold_full_q   <= 1'b0;
      bitcnt_q      <= 3'd0;
      ready_q       <= 1'b0;
      underrun_q    <= 1'b0;
      tog_restart_q <= 1'b0;
      tog_next_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_on_q      <= 1'b0;
      pix_rgb_q     <= 24'h000000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      bitcnt_q      <= bitcnt_d;
      ready_q       <= ready_d;
      underrun_q    <= underrun_d;
      tog_restart_q <= tog_restart_d;
      tog_next_q    <= tog_next_d;
      pix_valid_q   <= pix_valid_d;
      pix_on_q      <= pix_on_d;
      pix_rgb_q     <= pix_rgb_d;
    end
  end

  assign toggle_restart = tog_restart_q;
  assign toggle_next    = tog_next_q;
  assign pixel_valid    = pix_valid_q;
  assign pixel_on       = pix_on_q;
  assign pixel_rgb      = pix_rgb_q;
  assign ready          = ready_q;
  assign underrun       = underrun_q;

endmodule
